// File: rtl/modulation_sampler.sv
// -----------------------------------------------------------------------------
// modulation_sampler
//
// Read side of the modulation memory. A sample index is stepped through the
// modulation BRAM at a programmable rate (FREQ_DIV timer ticks per sample) and
// driven out as the memory read address. The data returned after RD_LAT cycles
// is captured into M, tagged with the index it came from (IDX), and announced
// with a one-cycle M_VALID strobe for the downstream duty/pulse-width stage.
//
// Ports:
//   CLK       system clock (single domain)
//   RST_N     synchronous active-low reset, sampled on rising CLK
//   START     level: 1 = run sampling, 0 = hold in IDLE
//   TICK      one-cycle base-rate pulse from the system timer
//   CYCLE     last valid sample index (period = CYCLE+1 samples)
//   FREQ_DIV  TICKs per sample; 0 behaves as 1
//   ADDR      read address to modulation memory
//   M_IN      read data from modulation memory
//   M         captured modulation sample
//   M_VALID   one-cycle pulse when M updates
//   IDX       index whose data currently sits in M
// -----------------------------------------------------------------------------
module modulation_sampler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              TICK,
  input  logic [ADDR_W-1:0] CYCLE,
  input  logic [15:0]       FREQ_DIV,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] M_IN,
  output logic [DATA_W-1:0] M,
  output logic              M_VALID,
  output logic [ADDR_W-1:0] IDX
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;         // current sample index == ADDR
  logic [15:0]         cnt_q, cnt_d;           // tick counter within a sample
  logic [ADDR_W-1:0]   sh_cycle_q, sh_cycle_d; // shadow CYCLE, reloaded at wrap
  logic [15:0]         sh_fdiv_q, sh_fdiv_d;   // shadow FREQ_DIV, reloaded at wrap

  // Read pipeline: one {valid, idx} entry per cycle of BRAM latency
  logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]   pipe_idx_q [RD_LAT];
  logic [ADDR_W-1:0]   pipe_idx_d [RD_LAT];

  logic [DATA_W-1:0]   m_q, m_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  logic [15:0]         fdiv_last_s;  // terminal count of the tick counter
  logic                launch_s;     // a read is issued with addr_d this cycle
  logic                flush_s;      // leaving RUN: drop everything in flight
  logic                capture_s;    // oldest pipeline entry lands in M

  // Terminal tick count; FREQ_DIV of 0 and 1 both give one TICK per sample
  always_comb begin
    if (sh_fdiv_q == 16'd0) begin
      fdiv_last_s = 16'd0;
    end else begin
      fdiv_last_s = sh_fdiv_q - 16'd1;
    end
  end

  // Sequencer: next state, index/address stepping and read launch
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sh_cycle_d = sh_cycle_q;
    sh_fdiv_d  = sh_fdiv_q;
    launch_s   = 1'b0;
    flush_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRIME: begin
        // Snapshot the programming and issue the read for index 0
        state_d    = ST_RUN;
        sh_cycle_d = CYCLE;
        sh_fdiv_d  = FREQ_DIV;
        addr_d     = {ADDR_W{1'b0}};
        cnt_d      = 16'd0;
        launch_s   = 1'b1;
      end

      ST_RUN: begin
        if (!START) begin
          state_d = ST_IDLE;
          flush_s = 1'b1;
        end else if (TICK) begin
          if (cnt_q == fdiv_last_s) begin
            cnt_d    = 16'd0;
            launch_s = 1'b1;
            if (addr_q == sh_cycle_q) begin
              // Period wrap is the only point where new programming is taken
              addr_d     = {ADDR_W{1'b0}};
              sh_cycle_d = CYCLE;
              sh_fdiv_d  = FREQ_DIV;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        flush_s = 1'b1;
      end
    endcase
  end

  // Read pipeline shift; a flush kills every in-flight read
  always_comb begin
    pipe_vld_d[0] = launch_s;
    pipe_idx_d[0] = addr_d;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    if (flush_s) begin
      pipe_vld_d = {RD_LAT{1'b0}};
    end else begin
      pipe_vld_d = pipe_vld_d;
    end
  end

  // Output capture: the oldest pipeline entry meets its data on M_IN now
  always_comb begin
    capture_s = pipe_vld_q[RD_LAT-1] & ~flush_s;
    m_valid_d = capture_s;
    if (capture_s) begin
      m_d   = M_IN;
      idx_d = pipe_idx_q[RD_LAT-1];
    end else begin
      m_d   = m_q;
      idx_d = idx_q;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      cnt_q      <= 16'd0;
      sh_cycle_q <= {ADDR_W{1'b0}};
      sh_fdiv_q  <= 16'd0;
      pipe_vld_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_idx_q[i] <= {ADDR_W{1'b0}};
      end
      m_q        <= {DATA_W{1'b0}};
      m_valid_q  <= 1'b0;
      idx_q      <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sh_cycle_q <= sh_cycle_d;
      sh_fdiv_q  <= sh_fdiv_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_idx_q[i] <= pipe_idx_d[i];
      end
      m_q        <= m_d;
      m_valid_q  <= m_valid_d;
      idx_q      <= idx_d;
    end
  end

  assign ADDR    = addr_q;
  assign M       = m_q;
  assign M_VALID = m_valid_q;
  assign IDX     = idx_q;

endmodule
